// File: rtl/nn_pkg.sv
// Shared definitions for the layer scheduler: state encoding, default
// layer geometry and the index-width helper.
package nn_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_RUN     = 3'd2,
      S_STORE   = 3'd3,
      S_RELEASE = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   localparam int BITS            = 16;
   localparam int FRACTIONAL_BITS = 11;
   localparam int IN_SIZE         = 50;
   localparam int NUM_NODES       = 10;

   // Width of an index into n items; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/layer_scheduler_argmax_tracker.sv
// Running signed maximum and its index. A clear restarts tracking; an
// update with first=1 always captures, otherwise only a strictly greater
// value captures, so ties keep the earliest index.
module argmax_tracker #(
   parameter int bits  = 16,
   parameter int idx_w = 4
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    clear,
   input  logic                    update,
   input  logic                    first,
   input  logic signed [bits-1:0]  value,
   input  logic [idx_w-1:0]        index,
   output logic [idx_w-1:0]        max_idx
);

   logic signed [bits-1:0] max_q, max_d;
   logic [idx_w-1:0]       idx_q, idx_d;

   // Next max/index: clear wins, then a qualifying update.
   always_comb begin
      max_d = max_q;
      idx_d = idx_q;
      if (clear) begin
         max_d = '0;
         idx_d = '0;
      end else if (update && (first || (value > max_q))) begin
         max_d = value;
         idx_d = index;
      end
   end

   // Tracker registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         max_q <= '0;
         idx_q <= '0;
      end else begin
         max_q <= max_d;
         idx_q <= idx_d;
      end
   end

   assign max_idx = idx_q;

endmodule

// File: rtl/layer_scheduler.sv
// Sequences num_nodes neurons through one shared node: LOAD gives the
// weight/bias memories a cycle, RUN holds node_start until node_ready,
// STORE captures the result, RELEASE waits for the node to re-arm.
//
// Handshake with the shared node: node_start is a registered level held
// high only in RUN; the node raises node_ready when node_out is valid and
// must lower it after node_start drops. node_ready is sampled only in RUN
// (to capture) and RELEASE (to wait for re-arm); it is ignored elsewhere.
module layer_scheduler
   import nn_pkg::*;
#(
   parameter int bits            = BITS,
   parameter int fractional_bits = FRACTIONAL_BITS,
   parameter int in_size         = IN_SIZE,
   parameter int num_nodes       = NUM_NODES
) (
   input  logic                                    clock,
   input  logic                                    reset_n,
   input  logic                                    start,
   output logic                                    busy,
   output logic                                    done,
   output logic [idx_width(num_nodes)-1:0]         node_sel,
   output logic [idx_width(num_nodes*in_size)-1:0] weight_base,
   output logic                                    node_start,
   input  logic                                    node_ready,
   input  logic signed [bits-1:0]                  node_out,
   output logic [num_nodes*bits-1:0]               results,
   output logic [idx_width(num_nodes)-1:0]         class_idx,
   output logic [2:0]                              state_dbg
);

   localparam int SW = idx_width(num_nodes);
   localparam int WW = idx_width(num_nodes*in_size);
   localparam logic [SW-1:0] LAST   = SW'(num_nodes - 1);
   localparam logic [WW-1:0] STRIDE = WW'(in_size);

   state_t                 state_q, state_d;
   logic [SW-1:0]          node_sel_q, node_sel_d;
   logic [WW-1:0]          weight_base_q, weight_base_d;
   logic signed [bits-1:0] results_q [num_nodes];
   logic signed [bits-1:0] results_d [num_nodes];
   logic                   node_start_q, node_start_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   trk_clear, trk_update;

   // Next-state, datapath updates and registered-output decode.
   always_comb begin
      state_d       = state_q;
      node_sel_d    = node_sel_q;
      weight_base_d = weight_base_q;
      results_d     = results_q;
      trk_clear     = 1'b0;
      trk_update    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               node_sel_d    = '0;
               weight_base_d = '0;
               trk_clear     = 1'b1;
               state_d       = S_LOAD;
            end
         end
         S_LOAD:  state_d = S_RUN;
         S_RUN: begin
            if (node_ready) state_d = S_STORE;
         end
         S_STORE: begin
            results_d[node_sel_q] = node_out;
            trk_update            = 1'b1;
            state_d               = S_RELEASE;
         end
         S_RELEASE: begin
            if (!node_ready) begin
               if (node_sel_q == LAST) begin
                  state_d = S_DONE;
               end else begin
                  node_sel_d    = node_sel_q + 1'b1;
                  weight_base_d = weight_base_q + STRIDE;
                  state_d       = S_LOAD;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Outputs are decoded from the next state and registered, so they
      // come straight from flops and cannot glitch.
      node_start_d = (state_d == S_RUN);
      busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d       = (state_d == S_DONE);
   end

   // Scheduler registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         node_sel_q    <= '0;
         weight_base_q <= '0;
         node_start_q  <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         for (int i = 0; i < num_nodes; i++) results_q[i] <= '0;
      end else begin
         state_q       <= state_d;
         node_sel_q    <= node_sel_d;
         weight_base_q <= weight_base_d;
         node_start_q  <= node_start_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         results_q     <= results_d;
      end
   end

   argmax_tracker #(.bits(bits), .idx_w(SW)) u_argmax (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (trk_clear),
      .update  (trk_update),
      .first   (node_sel_q == '0),
      .value   (node_out),
      .index   (node_sel_q),
      .max_idx (class_idx)
   );

   // Flatten the per-neuron results onto the output bus.
   always_comb begin
      results = '0;
      for (int i = 0; i < num_nodes; i++) results[i*bits +: bits] = results_q[i];
   end

   assign node_sel    = node_sel_q;
   assign weight_base = weight_base_q;
   assign node_start  = node_start_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_layer_scheduler.sv
// Bench for layer_scheduler: shared-node model with programmable latency
// and ready hold, a per-cycle compare process against a layer-level model,
// and directed plus randomized layers.
module tb_layer_scheduler;

   localparam int BW = 16;
   localparam int NN = 10;
   localparam int IS = 50;

   logic            clock = 1'b0;
   logic            reset_n = 1'b0;
   logic            start = 1'b0;
   logic            node_ready = 1'b0;
   logic [BW-1:0]   node_out = '0;
   logic            busy, done, node_start;
   logic [3:0]      node_sel, class_idx;
   logic [8:0]      weight_base;
   logic [NN*BW-1:0] results;
   logic [2:0]      state_dbg;

   int n_checks = 0;
   int n_errors = 0;

   layer_scheduler dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .node_sel    (node_sel),
      .weight_base (weight_base),
      .node_start  (node_start),
      .node_ready  (node_ready),
      .node_out    (node_out),
      .results     (results),
      .class_idx   (class_idx),
      .state_dbg   (state_dbg)
   );

   // Clock.
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- shared node model ----------------
   logic [BW-1:0] vals [NN];
   int lat  = 3;
   int hold = 0;
   int cnt  = 0;
   int hcnt = 0;
   logic ns_s = 1'b0;

   // Behaves like a registered node: reacts to node_start as seen before
   // each rising edge, updating its outputs just after the edge.
   always begin
      @(negedge clock);
      ns_s = node_start;
      @(posedge clock);
      #1;
      if (!reset_n) begin
         node_ready = 1'b0; cnt = 0; hcnt = 0;
      end else if (ns_s) begin
         hcnt = 0;
         if (!node_ready) begin
            cnt++;
            if (cnt >= lat) node_ready = 1'b1;
         end
      end else begin
         cnt = 0;
         if (node_ready) begin
            if (hcnt < hold) hcnt++;
            else begin node_ready = 1'b0; hcnt = 0; end
         end
      end
      node_out = node_ready ? vals[node_sel] : 16'hDEAD;
   end

   // ---------------- layer-level reference model ----------------
   logic [8:0]    exp_q[$];
   logic [BW-1:0] exp_res [NN];
   int            exp_class = 0;
   int            done_cnt = 0;
   logic          ns_prev = 1'b0;

   // Expected results are the node values; class is the lowest index
   // holding the signed maximum. Each layer visits neurons 0..NN-1 in
   // order, each with its base at index*in_size.
   task automatic set_expect();
      logic signed [BW-1:0] mx;
      mx = $signed(vals[0]);
      for (int i = 0; i < NN; i++) begin
         exp_res[i] = vals[i];
         if ($signed(vals[i]) > mx) mx = $signed(vals[i]);
      end
      for (int i = NN-1; i >= 0; i--) if ($signed(vals[i]) == mx) exp_class = i;
      for (int i = 0; i < NN; i++) exp_q.push_back(9'(i*IS));
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clock) begin
      if (!reset_n) begin
         ns_prev = 1'b0;
      end else begin
         chk("wbase_stride", 32'(weight_base), 32'(node_sel) * IS);
         if (node_start) chk("node_start_busy", 32'(busy), 32'd1);
         if (node_start && !ns_prev) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL extra_node_run: node_sel %0d weight_base %0d with none expected", node_sel, weight_base);
            end else begin
               chk("wbase_seq", 32'(weight_base), 32'(exp_q.pop_front()));
            end
         end
         if (done) begin
            done_cnt++;
            chk("done_not_busy", 32'(busy), 32'd0);
            for (int i = 0; i < NN; i++) chk("result", 32'(results[i*BW +: BW]), 32'(exp_res[i]));
            chk("class_idx", 32'(class_idx), 32'(exp_class));
         end
         ns_prev = node_start;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_done(input int target, input string tag);
      for (int k = 0; k < 4000 && done_cnt < target; k++) @(posedge clock);
      chk({tag, "_done_seen"}, 32'(done_cnt), 32'(target));
   endtask

   task automatic post_layer(input int target, input string tag);
      repeat (4) @(posedge clock);
      #1;
      chk({tag, "_one_done"}, 32'(done_cnt), 32'(target));
      chk({tag, "_all_neurons"}, 32'(exp_q.size()), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
      exp_q.delete();
   endtask

   task automatic run_layer(input string tag);
      int target;
      set_expect();
      target = done_cnt + 1;
      @(posedge clock); #1 start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
      repeat (2) @(posedge clock);
      #1 chk({tag, "_busy"}, 32'(busy), 32'd1);
      wait_done(target, tag);
      post_layer(target, tag);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_node_start"}, 32'(node_start), 32'd0);
      chk({tag, "_node_sel"}, 32'(node_sel), 32'd0);
      chk({tag, "_wbase"}, 32'(weight_base), 32'd0);
      chk({tag, "_class"}, 32'(class_idx), 32'd0);
      chk({tag, "_state"}, 32'(state_dbg), 32'd0);
      for (int i = 0; i < NN; i++) chk({tag, "_result"}, 32'(results[i*BW +: BW]), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int dc, target;
      for (int i = 0; i < NN; i++) vals[i] = '0;
      #12;
      check_zero("reset");
      @(negedge clock) reset_n = 1'b1;

      // Ascending outputs: last neuron wins.
      lat = 3; hold = 0;
      for (int i = 0; i < NN; i++) vals[i] = 16'((i + 1) * 256);
      run_layer("ascend");
      chk("ascend_model_class", 32'(exp_class), 32'd9);
      chk("ascend_class_lit", 32'(class_idx), 32'd9);
      chk("ascend_res3_lit", 32'(results[3*BW +: BW]), 32'h0400);
      chk("ascend_res9_lit", 32'(results[9*BW +: BW]), 32'h0A00);

      // All negative, neuron 4 least negative.
      for (int i = 0; i < NN; i++) vals[i] = 16'hFF00;
      vals[4] = 16'hFF80;
      run_layer("negative");
      chk("negative_model_class", 32'(exp_class), 32'd4);
      chk("negative_class_lit", 32'(class_idx), 32'd4);

      // Tie between 2 and 7: lowest index kept.
      for (int i = 0; i < NN; i++) vals[i] = 16'(i * 16);
      vals[2] = 16'h0400; vals[7] = 16'h0400;
      run_layer("tie");
      chk("tie_model_class", 32'(exp_class), 32'd2);
      chk("tie_class_lit", 32'(class_idx), 32'd2);

      // Reset during RUN of neuron 5.
      for (int i = 0; i < NN; i++) vals[i] = 16'($urandom_range(0, 16'hFFFF));
      set_expect();
      dc = done_cnt;
      @(posedge clock); #1 start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
      begin
         int k;
         for (k = 0; k < 2000 && !(node_start && node_sel == 4'd5); k++) @(negedge clock);
         chk("midreset_reached_n5", 32'(node_start && node_sel == 4'd5), 32'd1);
      end
      #2 reset_n = 1'b0;
      #1 check_zero("midreset");
      exp_q.delete();
      repeat (3) @(posedge clock);
      @(negedge clock) reset_n = 1'b1;
      repeat (5) @(posedge clock);
      #1 chk("midreset_no_done", 32'(done_cnt), 32'(dc));
      chk("midreset_still_idle", 32'(busy), 32'd0);
      for (int i = 0; i < NN; i++) vals[i] = 16'((NN - i) * 100);
      run_layer("after_reset");
      chk("after_reset_class_lit", 32'(class_idx), 32'd0);

      // start held high, node_ready lingers two cycles after node_start drops.
      hold = 2; lat = 2;
      for (int i = 0; i < NN; i++) vals[i] = 16'($urandom_range(0, 16'hFFFF));
      set_expect();
      set_expect();
      target = done_cnt + 2;
      @(posedge clock); #1 start = 1'b1;
      wait_done(target, "held");
      #1 start = 1'b0;
      post_layer(target, "held");

      // Randomized layers.
      for (int r = 0; r < 6; r++) begin
         lat  = $urandom_range(1, 4);
         hold = $urandom_range(0, 3);
         for (int i = 0; i < NN; i++) vals[i] = 16'($urandom_range(0, 16'hFFFF));
         if (r == 2) for (int i = 0; i < NN; i++) vals[i] = 16'($urandom_range(0, 3));
         run_layer("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global time limit.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, got hang expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/layer_scheduler.md
LAYER_SCHEDULER -- requirements
Module: layer_scheduler

Interface
REQ-001 SHALL have parameter bits, default 16, meaning fixed-point word width of node output and results.
REQ-002 SHALL have parameter fractional_bits, default 11, meaning fraction bits; passed through only, with no arithmetic use.
REQ-003 SHALL have parameter in_size, default 50, meaning weights per neuron (stride into weight memory).
REQ-004 SHALL have parameter num_nodes, default 10, meaning neurons in the layer sequenced through one shared node.
REQ-005 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  layer request; sampled only in IDLE.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE and DONE.
REQ-009 SHALL have port done  output  1  one-cycle pulse on layer completion.
REQ-010 SHALL have port node_sel  output  $clog2(num_nodes)  index of neuron currently on the shared node; drives bias memory address.
REQ-011 SHALL have port weight_base  output  $clog2(num_nodes*in_size)  node_sel*in_size, registered.
REQ-012 SHALL have port node_start  output  1  start level to shared node.
REQ-013 SHALL have port node_ready  input  1  shared-node completion level.
REQ-014 SHALL have port node_out  input  signed bits  shared-node result, valid while node_ready high.
REQ-015 SHALL have port results  output  signed bits x num_nodes  per-neuron outputs, registered.
REQ-016 SHALL have port class_idx  output  $clog2(num_nodes)  argmax of results, valid from done onward.

Function
REQ-017 SHALL implement states IDLE, LOAD, RUN, STORE, RELEASE, DONE.
REQ-018 IDLE: start=1 -> node_sel=0, weight_base=0, argmax tracker cleared, go LOAD.
REQ-019 LOAD: exactly one cycle with node_start=0, allowing 1-cycle-latency weight/bias memories to present data; go RUN.
REQ-020 RUN: node_start=1 held; stay until node_ready=1, then go STORE.
REQ-021 STORE: results[node_sel] <= node_out; if node_sel==0 or node_out > running max (signed, strict), record max and class_idx <= node_sel; go RELEASE.
REQ-022 RELEASE: node_start=0; wait until node_ready=0 (node re-armed); then if node_sel==num_nodes-1 go DONE, else node_sel+1, weight_base+in_size, go LOAD.
REQ-023 DONE: done=1 for one cycle, go IDLE; results and class_idx hold until next start.
REQ-024 Ties SHALL keep the lowest index (strict greater-than compare).
REQ-025 start asserted while busy SHALL be ignored (no queuing).
REQ-026 node_ready asserted in LOAD SHALL be ignored; only RUN samples it.
REQ-027 node_start SHALL be glitch-free, driven from registered state only.
REQ-028 Minimum per-neuron latency SHALL be LOAD(1)+RUN(≥1)+STORE(1)+RELEASE(≥1) cycles; layer latency is the sum plus DONE(1).

Reset
REQ-029 reset_n=0 SHALL immediately force IDLE, busy=0, done=0, node_start=0, node_sel=0, weight_base=0, class_idx=0, all results=0.
REQ-030 Reset mid-layer SHALL abandon the layer with no done pulse; partial results cleared.
REQ-031 Deassertion SHALL take effect on the next rising clock edge; no start is accepted in the deassertion cycle unless already in IDLE.

Structure
REQ-032 A shared package nn_pkg SHALL hold the state enum, default bits/fractional_bits/in_size/num_nodes constants, and the node-index width function.
REQ-033 One sub-module, argmax_tracker (running max + index, clear/update inputs), SHALL be instantiated; the shared node instance stays outside this block.

Verification
REQ-034 Directed scenarios: start with node model returning 0x0100,0x0200,...,0x0A00 (ready 3 cycles after start) -> results match, class_idx=9, one done pulse, weight_base sequence 0,50,...,450.
REQ-035 Directed scenarios: outputs all 0xFF00 (negative) except neuron 4 = 0xFF80 -> class_idx=4.
REQ-036 Directed scenarios: neurons 2 and 7 tie at 0x0400 (others lower) -> class_idx=2.
REQ-037 Directed scenarios: reset_n pulsed low during RUN of neuron 5 -> outputs zeroed, busy=0, no done; a fresh start completes normally.
REQ-038 Directed scenarios: start held high throughout, node_ready held high 2 extra cycles after node_start drop -> no duplicate STORE, one done per layer, next layer starts only from IDLE.
